// File: rtl/mem_address_unit_pkg.sv
// Shared encodings and the alignment check for the memory address unit.
//   size_e  : access size encodings (reserved size behaves as word)
//   state_e : address unit FSM states
//   align_fault() : 1 when the low address bits violate the access size
package mem_address_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SINGLE = 2'b01,
        BURST  = 2'b10
    } state_e;

    // MIPS-style alignment: byte never faults, half needs bit 0 clear,
    // word (and reserved) needs both low bits clear.
    function automatic logic align_fault(input logic [1:0] addr_lo, input logic [1:0] size);
        logic fault;
        case (size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = addr_lo[0];
            default: fault = |addr_lo;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/mem_address_unit_addr_src_select.sv
// Combinational NUM_SRC-way address source selector.
//   src_flat   : packed sources, source i at [i*WIDTH +: WIDTH]
//   addr_sel   : source index; out-of-range indices pick the last source
//   sel_addr_c : selected address (combinational)
module mem_address_unit_addr_src_select #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 5,
    parameter int unsigned SEL_W   = 3
) (
    input  logic [NUM_SRC*WIDTH-1:0] src_flat,
    input  logic [SEL_W-1:0]         addr_sel,
    output logic [WIDTH-1:0]         sel_addr_c
);

    // Last source (the ALU result) is the fallback for any unmatched index.
    always_comb begin
        sel_addr_c = src_flat[(NUM_SRC-1)*WIDTH +: WIDTH];
        for (int i = 0; i < int'(NUM_SRC) - 1; i++) begin
            if (addr_sel == SEL_W'(i)) begin
                sel_addr_c = src_flat[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mem_address_unit.sv
// Memory address unit: selects an address source, captures it into the
// address register and drives single accesses or auto-incrementing bursts.
//   clk, reset        : clock and asynchronous active-high reset
//   src_flat/addr_sel : packed address sources and source index
//   size              : access size, sampled at capture
//   load/burst_start  : start a single access / a burst (burst wins)
//   burst_len         : beats per burst, 0 behaves as 1
//   mem_ready         : memory accepted the current beat
//   addr_out/addr_valid : registered address and request strobe
//   busy/done         : burst in progress / one-cycle end-of-burst pulse
//   misaligned        : alignment fault of the last captured address
module mem_address_unit
    import mem_address_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 5,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned STEP    = 4,
    localparam int unsigned SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_flat,
    input  logic [SEL_W-1:0]         addr_sel,
    input  logic [1:0]               size,
    input  logic                     load,
    input  logic                     burst_start,
    input  logic [CNT_W-1:0]         burst_len,
    input  logic                     mem_ready,
    output logic [WIDTH-1:0]         addr_out,
    output logic                     addr_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     misaligned
);

    state_e             state, state_d;
    logic [CNT_W-1:0]   remaining, remaining_d;
    logic [WIDTH-1:0]   addr_d;
    logic               valid_d, busy_d, done_d, mis_d;
    logic [WIDTH-1:0]   sel_addr_c;
    logic               fault_c;

    mem_address_unit_addr_src_select #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_sel (
        .src_flat   (src_flat),
        .addr_sel   (addr_sel),
        .sel_addr_c (sel_addr_c)
    );

    assign fault_c = align_fault(sel_addr_c[1:0], size);

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            addr_out   <= '0;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_d;
            remaining  <= remaining_d;
            addr_out   <= addr_d;
            addr_valid <= valid_d;
            busy       <= busy_d;
            done       <= done_d;
            misaligned <= mis_d;
        end
    end

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        state_d     = state;
        remaining_d = remaining;
        addr_d      = addr_out;
        valid_d     = addr_valid;
        busy_d      = busy;
        done_d      = 1'b0;
        mis_d       = misaligned;

        case (state)
            IDLE: begin
                if (burst_start) begin
                    addr_d = sel_addr_c;
                    mis_d  = fault_c;
                    if (fault_c) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        remaining_d = (burst_len == '0) ? '0 : burst_len - CNT_W'(1);
                        valid_d     = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = BURST;
                    end
                end else if (load) begin
                    addr_d = sel_addr_c;
                    mis_d  = fault_c;
                    if (fault_c) begin
                        valid_d = 1'b0;
                    end else begin
                        valid_d = 1'b1;
                        state_d = SINGLE;
                    end
                end
            end

            SINGLE: begin
                if (mem_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end

            BURST: begin
                if (mem_ready) begin
                    if (remaining != '0) begin
                        addr_d      = addr_out + WIDTH'(STEP);
                        remaining_d = remaining - CNT_W'(1);
                    end else begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_address_unit.md
Name: mem_address_unit

Overview:
Parametrised successor to the memory-address selector in the multicycle datapath. Selects one of NUM_SRC address sources (PC, temporaries, ALU result, ...) and captures it into an address register. Supports single-access loads and auto-incrementing multi-word bursts with a memory-ready handshake. Flags MIPS-style misalignment for byte/half/word accesses. Sits between the control unit/datapath registers and the memory address port.

Parameters:
WIDTH, 32, address width in bits
NUM_SRC, 5, number of address sources (index NUM_SRC-1 is the ALU result)
CNT_W, 4, burst length counter width
STEP, 4, byte increment per burst beat

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
src_flat  in  NUM_SRC*WIDTH  packed sources; source i occupies bits [i*WIDTH +: WIDTH]
addr_sel  in  SEL_W  source index; SEL_W = max(1, clog2(NUM_SRC))
size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
load  in  1  capture the selected source for a single access
burst_start  in  1  capture the selected source and begin a burst
burst_len  in  CNT_W  number of beats; 0 is treated as 1
mem_ready  in  1  memory accepted the current beat
addr_out  out  WIDTH  registered address to memory
addr_valid  out  1  addr_out is a live request
busy  out  1  burst in progress
done  out  1  one-cycle pulse after the final burst beat is accepted
misaligned  out  1  captured address violates size alignment

Behaviour:
- Reset is asynchronous and active-high and may arrive at any time, including mid-burst. Reset values: addr_out=0, addr_valid=0, busy=0, done=0, misaligned=0. The state goes to IDLE and the remaining-beat counter is cleared.
- Source select: addr_sel >= NUM_SRC selects source NUM_SRC-1, the ALU default.
- Alignment rule: byte accesses are always aligned. Half requires addr[0]=0. Word or reserved size requires addr[1:0]=00. Alignment is evaluated on the selected source at capture and registered with it. size is sampled only at capture.
- States: IDLE, SINGLE, BURST.
- IDLE, burst_start=1 (has priority over a simultaneous load):
  - Next edge: addr_out <= selected source; misaligned <= check result.
  - If misaligned: stay IDLE; addr_valid=0; busy=0; done is not pulsed.
  - Otherwise: remaining <= max(burst_len,1)-1; addr_valid=1; busy=1; go to BURST.
- IDLE, load=1:
  - Next edge: capture address and misaligned as above.
  - If aligned: addr_valid=1; go to SINGLE.
  - If misaligned: addr_valid=0; stay IDLE.
- SINGLE: on mem_ready, the next edge clears addr_valid and returns to IDLE. No done pulse. addr_out holds its value.
- BURST, mem_ready=1 and remaining>0: addr_out <= addr_out + STEP (modulo 2^WIDTH, wraps silently); remaining decrements.
- BURST, mem_ready=1 and remaining=0: addr_valid<=0, busy<=0, done<=1 for one cycle; go to IDLE.
- BURST, mem_ready=0: all outputs hold.
- load and burst_start are ignored outside IDLE. A new capture is accepted in the cycle after done.
- mem_ready is ignored in IDLE.
- misaligned holds until the next capture.
- Latency: capture to addr_valid is 1 cycle. An N-beat burst with mem_ready held high takes N cycles of addr_valid, and done follows in the cycle after the last beat.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and state encodings (IDLE, SINGLE, BURST).
- One natural sub-module, addr_src_select: the combinational NUM_SRC-way selector with fallback to the last source.
- The alignment check is a package function.

Test Plan:
- Sources PC=0x100, ALU=0x2000; addr_sel=7 with load and size=10 -> next cycle addr_out=0x2000, addr_valid=1; mem_ready -> addr_valid=0, done stays 0.
- burst_start from source 1=0x40, burst_len=3, mem_ready high -> addr_out 0x40, 0x44, 0x48 with addr_valid=1; done pulses once in the following cycle; busy=0.
- Same burst with mem_ready low every other cycle -> addr_out holds during stalls; exactly 3 accepted beats; done is still a single pulse.
- Capture 0x102: size=01 -> misaligned=0; size=10 -> misaligned=1, addr_valid=0, busy=0; capture 0x103 with size=00 -> misaligned=0.
- Burst from 0xFFFFFFFC, burst_len=2 -> addr_out 0xFFFFFFFC then 0x00000000; burst_len=0 -> exactly one beat.
- Assert reset mid-burst -> immediately addr_out=0, addr_valid=0, busy=0; after release a new burst_start works.
- Simultaneous load and burst_start in IDLE -> burst taken (busy=1); load pulsed during BURST -> ignored.
